// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and grant encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  typedef enum logic {GNT_CPU, GNT_DMA} grant_t;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 8
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_arb2_rr.sv
// Combinational two-way picker: sole requester wins, ties go round-robin or to the CPU.
module arb2_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last_grant,
  input  logic       fixed_prio,
  output grant_t     grant
);

  always_comb begin
    grant = GNT_CPU;
    case (req)
      2'b10:   grant = GNT_DMA;
      2'b11:   if (!fixed_prio && last_grant == GNT_CPU) grant = GNT_DMA;
      default: grant = GNT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the core's memory port and a DMA/loader port,
// one transaction in flight: issue, wait out the read latency, respond.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  input  logic [DW/8-1:0] cpu_wmask,
  output logic            cpu_ack,
  output logic [DW-1:0]   cpu_rdata,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [AW-1:0]   dma_addr,
  input  logic [DW-1:0]   dma_wdata,
  input  logic [DW/8-1:0] dma_wmask,
  output logic            dma_ack,
  output logic [DW-1:0]   dma_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata
);

  state_t             state;
  grant_t             last_grant;
  grant_t             gnt_q;
  grant_t             pick;
  logic               we_q;
  logic [CNT_W-1:0]   cnt;
  logic [DW-1:0]      rdata_q;

  arb2_rr u_arb (
    .req        ({dma_req, cpu_req}),
    .last_grant (last_grant),
    .fixed_prio (FIXED_PRIO != 0),
    .grant      (pick)
  );

  // mem_addr/wdata/wmask double as the latch registers and hold between transactions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_DMA;
      gnt_q      <= GNT_CPU;
      we_q       <= 1'b0;
      cnt        <= '0;
      rdata_q    <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_ack    <= 1'b0;
      dma_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            gnt_q      <= pick;
            last_grant <= pick;
            mem_en     <= 1'b1;
            state      <= ACCESS;
            if (pick == GNT_DMA) begin
              we_q      <= dma_we;
              mem_we    <= dma_we;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
              mem_wmask <= dma_wmask;
            end else begin
              we_q      <= cpu_we;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_wmask <= cpu_wmask;
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            state <= RESP;
            if (gnt_q == GNT_DMA) begin
              dma_ack   <= 1'b1;
              dma_rdata <= rdata_q;
            end else begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= rdata_q;
            end
          end else begin
            cnt   <= CNT_W'(MEM_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rdata_q <= mem_rdata;
            state   <= RESP;
            if (gnt_q == GNT_DMA) begin
              dma_ack   <= 1'b1;
              dma_rdata <= mem_rdata;
            end else begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: four arbiter instances (RR lat2, fixed-prio lat2, RR lat1, RR lat4) each with a memory model.
module tb_mem_port_arbiter;

  localparam int unsigned N = 4;

  logic        clk;
  logic        reset;
  logic        cpu_req   [N];
  logic        cpu_we    [N];
  logic [31:0] cpu_addr  [N];
  logic [31:0] cpu_wdata [N];
  logic [3:0]  cpu_wmask [N];
  logic        cpu_ack   [N];
  logic [31:0] cpu_rdata [N];
  logic        dma_req   [N];
  logic        dma_we    [N];
  logic [31:0] dma_addr  [N];
  logic [31:0] dma_wdata [N];
  logic [3:0]  dma_wmask [N];
  logic        dma_ack   [N];
  logic [31:0] dma_rdata [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [3:0]  mem_wmask [N];
  logic [31:0] mem_rdata [N];

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < N; g++) begin : u
    localparam int unsigned LAT = (g == 2) ? 1 : (g == 3) ? 4 : 2;
    localparam int unsigned FP  = (g == 1) ? 1 : 0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .FIXED_PRIO(FP)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req[g]),
      .cpu_we    (cpu_we[g]),
      .cpu_addr  (cpu_addr[g]),
      .cpu_wdata (cpu_wdata[g]),
      .cpu_wmask (cpu_wmask[g]),
      .cpu_ack   (cpu_ack[g]),
      .cpu_rdata (cpu_rdata[g]),
      .dma_req   (dma_req[g]),
      .dma_we    (dma_we[g]),
      .dma_addr  (dma_addr[g]),
      .dma_wdata (dma_wdata[g]),
      .dma_wmask (dma_wmask[g]),
      .dma_ack   (dma_ack[g]),
      .dma_rdata (dma_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_wmask (mem_wmask[g]),
      .mem_rdata (mem_rdata[g])
    );

    // Memory model: read data is valid only in the cycle exactly LAT cycles after mem_en
    logic [31:0] mem [0:63];
    logic [31:0] pdata;
    int          pcnt;

    always @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < 64; k++) mem[k] <= 32'hC0DE_0000 | 32'(k);
        mem[4] <= 32'hDEAD_BEEF;
        mem[8] <= 32'hAABB_CCDD;
        pcnt   <= 0;
        pdata  <= '0;
      end else begin
        if (pcnt > 0) pcnt <= pcnt - 1;
        if (mem_en[g] && mem_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (mem_wmask[g][b]) mem[mem_addr[g][7:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
        end else if (mem_en[g]) begin
          pdata <= mem[mem_addr[g][7:2]];
          pcnt  <= int'(LAT);
        end
      end
    end

    assign mem_rdata[g] = (pcnt == 1) ? pdata : 32'hBADB_AD00;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    for (int i = 0; i < int'(N); i++) begin
      cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0; cpu_wmask[i] = '0;
      dma_req[i] = 1'b0; dma_we[i] = 1'b0; dma_addr[i] = '0; dma_wdata[i] = '0; dma_wmask[i] = '0;
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One transaction from an idle port; lat is the ack cycle counted from the request cycle (-1 on timeout)
  task automatic txn(input int i, input bit dma, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] mask,
                     output int lat, output logic [31:0] rd);
    tick();
    if (dma) begin
      dma_req[i] = 1'b1; dma_we[i] = we; dma_addr[i] = addr; dma_wdata[i] = wdata; dma_wmask[i] = mask;
    end else begin
      cpu_req[i] = 1'b1; cpu_we[i] = we; cpu_addr[i] = addr; cpu_wdata[i] = wdata; cpu_wmask[i] = mask;
    end
    lat = -1;
    rd  = '0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (dma ? dma_ack[i] : cpu_ack[i]) begin
        lat = n;
        rd  = dma ? dma_rdata[i] : cpu_rdata[i];
        break;
      end
    end
    cpu_req[i] = 1'b0;
    dma_req[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;

    reset_dut();
    check("rst_cpu_ack", cpu_ack[0], 0);
    check("rst_cpu_rdata", cpu_rdata[0], 0);
    check("rst_mem_en", mem_en[0], 0);
    check("rst_mem_addr", mem_addr[0], 0);
    check("rst_mem_wmask", mem_wmask[0], 0);

    // CPU read 0x10 with cycle-accurate checks
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h10;
    tick();
    check("t1_mem_en_c1", mem_en[0], 1);
    check("t1_mem_we_c1", mem_we[0], 0);
    check("t1_mem_addr_c1", mem_addr[0], 32'h10);
    tick();
    check("t1_mem_en_c2", mem_en[0], 0);
    tick();
    check("t1_ack_c3", cpu_ack[0], 0);
    tick();
    check("t1_cpu_ack_c4", cpu_ack[0], 1);
    check("t1_cpu_rdata_c4", cpu_rdata[0], 32'hDEAD_BEEF);
    check("t1_dma_ack_c4", dma_ack[0], 0);
    check("t1_dma_rdata_c4", dma_rdata[0], 0);
    cpu_req[0] = 1'b0;
    tick();
    check("t1_ack_c5", cpu_ack[0], 0);
    check("t1_addr_hold", mem_addr[0], 32'h10);

    // DMA partial write
    dma_req[0] = 1'b1; dma_we[0] = 1'b1; dma_addr[0] = 32'h20;
    dma_wdata[0] = 32'h1234_5678; dma_wmask[0] = 4'b0011;
    tick();
    check("t2_mem_en", mem_en[0], 1);
    check("t2_mem_we", mem_we[0], 1);
    check("t2_mem_addr", mem_addr[0], 32'h20);
    check("t2_mem_wdata", mem_wdata[0], 32'h1234_5678);
    check("t2_mem_wmask", mem_wmask[0], 4'b0011);
    tick();
    check("t2_dma_ack", dma_ack[0], 1);
    check("t2_cpu_ack", cpu_ack[0], 0);
    dma_req[0] = 1'b0;
    tick();
    check("t2_we_pulse", mem_we[0], 0);
    check("t2_wdata_hold", mem_wdata[0], 32'h1234_5678);
    txn(0, 1'b0, 1'b0, 32'h20, '0, '0, lat, rd);
    check("t2_readback_lat", lat, 4);
    check("t2_readback", rd, 32'hAABB_5678);

    // Simultaneous reads after reset
    begin : t3
      int          c_ack, d_en, d_ack;
      logic [31:0] c_rd, d_rd;
      c_ack = -1; d_en = -1; d_ack = -1; c_rd = '0; d_rd = '0;
      reset_dut();
      cpu_req[0] = 1'b1; cpu_addr[0] = 32'h10;
      dma_req[0] = 1'b1; dma_addr[0] = 32'h14;
      for (int n = 1; n <= 15; n++) begin
        tick();
        if (cpu_ack[0] && c_ack < 0) begin c_ack = n; c_rd = cpu_rdata[0]; cpu_req[0] = 1'b0; end
        if (mem_en[0] && mem_addr[0] == 32'h14 && d_en < 0) d_en = n;
        if (dma_ack[0] && d_ack < 0) begin d_ack = n; d_rd = dma_rdata[0]; dma_req[0] = 1'b0; end
      end
      check("t3_cpu_ack_cycle", c_ack, 4);
      check("t3_cpu_rdata", c_rd, 32'hDEAD_BEEF);
      check("t3_dma_en_cycle", d_en, 6);
      check("t3_dma_ack_cycle", d_ack, 9);
      check("t3_dma_rdata", d_rd, 32'hC0DE_0005);
    end

    // Continuous requests on both ports: round-robin (inst 0) vs fixed priority (inst 1)
    begin : t4
      int         cnt [2];
      logic [5:0] ord [2];
      for (int i = 0; i < 2; i++) begin
        cnt[i] = 0; ord[i] = '0;
        cpu_req[i] = 1'b1; cpu_we[i] = 1'b0; cpu_addr[i] = 32'h10;
        dma_req[i] = 1'b1; dma_we[i] = 1'b0; dma_addr[i] = 32'h14;
      end
      for (int n = 0; n < 80; n++) begin
        tick();
        for (int i = 0; i < 2; i++) begin
          if ((cpu_ack[i] || dma_ack[i]) && cnt[i] < 6) begin
            ord[i][cnt[i]] = dma_ack[i];
            cnt[i] = cnt[i] + 1;
            if (cnt[i] == 6) begin cpu_req[i] = 1'b0; dma_req[i] = 1'b0; end
          end
        end
        if (cnt[0] == 6 && cnt[1] == 6) break;
      end
      check("t4_rr_count", cnt[0], 6);
      check("t4_rr_order", ord[0], 6'b101010);
      check("t4_fp_count", cnt[1], 6);
      check("t4_fp_order", ord[1], 6'b000000);
    end

    // Reset during WAIT of a CPU read
    tick();
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h10;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("t5_mem_en", mem_en[0], 0);
    check("t5_cpu_ack", cpu_ack[0], 0);
    check("t5_mem_addr", mem_addr[0], 0);
    cpu_req[0] = 1'b0;
    tick();
    check("t5_cpu_ack_held", cpu_ack[0], 0);
    reset = 1'b0;
    txn(0, 1'b1, 1'b0, 32'h14, '0, '0, lat, rd);
    check("t5_dma_lat", lat, 4);
    check("t5_dma_rdata", rd, 32'hC0DE_0005);

    // Latency sweep
    txn(2, 1'b0, 1'b0, 32'h18, '0, '0, lat, rd);
    check("t6_lat1_cycle", lat, 3);
    check("t6_lat1_rdata", rd, 32'hC0DE_0006);
    txn(3, 1'b1, 1'b0, 32'h1C, '0, '0, lat, rd);
    check("t6_lat4_cycle", lat, 6);
    check("t6_lat4_rdata", rd, 32'hC0DE_0007);
    txn(2, 1'b0, 1'b1, 32'h18, 32'hFFFF_FFFF, 4'b1000, lat, rd);
    check("t6_lat1_wr_cycle", lat, 2);
    txn(2, 1'b0, 1'b0, 32'h18, '0, '0, lat, rd);
    check("t6_lat1_readback", rd, 32'hFFDE_0006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
